// File: rtl/uart_rx_pkg.sv
// Shared types and widths for the 8N1 UART receiver.
package uart_rx_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability chain; both stages reset to the line's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule : uart_rx_sync2

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, mid-bit sampling,
// valid/ready byte output with one-cycle framing-error and overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKRATE  = 24000000,
  parameter int unsigned BAUDRATE = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned DIVIDER = CLKRATE / BAUDRATE;
  localparam int unsigned HALF    = DIVIDER / 2;
  localparam int unsigned CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  generate
    if (DIVIDER < 4) begin : g_bad_divider
      $error("uart_rx: CLKRATE/BAUDRATE must be at least 4");
    end
  endgenerate

  logic s2;
  logic s3_q;
  logic start_c;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (s2)
  );

  // Delayed copy of the synchronised line for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3_q <= 1'b1;
    else        s3_q <= s2;
  end

  assign start_c = !s2 && s3_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame sequencing, bit sampling and output handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    valid_d     = valid_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_START;
          cnt_d   = CNT_W'(HALF - 1);
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!s2) begin
            state_d = ST_DATA;
            cnt_d   = CNT_W'(DIVIDER - 1);
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d[bit_q] = s2;
          cnt_d          = CNT_W'(DIVIDER - 1);
          if (bit_q == BIT_IDX_W'(DATA_W - 1)) state_d = ST_STOP;
          else                                 bit_d   = bit_q + BIT_IDX_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (s2) begin
            // A pending byte may be replaced only if it is consumed this cycle.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (s2) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign valid     = valid_q;
  assign data      = data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned DIV  = 16;
  localparam int unsigned LAT  = 154; // t0 -> stop sample edge

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int checks;
  int errors;

  int cyc;
  int rise_cyc;
  int high_cnt;
  int fe_cnt;
  int fe_cyc;
  int ov_cnt;
  int ov_cyc;
  int both_cnt;
  logic vprev;
  logic [7:0] acc_q[$];

  uart_rx #(.CLKRATE(16), .BAUDRATE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .valid     (valid),
    .data      (data),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle and log events with the cycle of the edge that caused them.
  always @(negedge clk) begin
    if (valid && !vprev) rise_cyc = cyc;
    if (valid) high_cnt = high_cnt + 1;
    if (valid && ready) acc_q.push_back(data);
    if (frame_err) begin fe_cnt = fe_cnt + 1; fe_cyc = cyc; end
    if (overrun) begin ov_cnt = ov_cnt + 1; ov_cyc = cyc; end
    if (frame_err && overrun) both_cnt = both_cnt + 1;
    vprev = valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(DIV);
    end
    rx = stop;
    wait_cycles(DIV);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    checks++;
    if (valid !== 1'b0 || data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h fe=%b ov=%b, want 0 00 0 0",
               valid, data, frame_err, overrun);
    end
    rst_n = 1'b1;
    wait_cycles(10);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%b want 0", valid);
    end
  endtask

  task automatic test_single_byte();
    int t0, n0, h0, f0;
    n0 = acc_q.size(); h0 = high_cnt; f0 = fe_cnt;
    t0 = cyc + 1;
    send_frame(8'hAA, 1'b1);
    wait_cycles(20);
    checks++;
    if (rise_cyc !== t0 + LAT) begin
      errors++;
      $display("FAIL single_latency: valid rose at %0d want %0d", rise_cyc, t0 + LAT);
    end
    checks++;
    if (acc_q.size() !== n0 + 1 || acc_q[acc_q.size()-1] !== 8'hAA) begin
      errors++;
      $display("FAIL single_data: count=%0d last=%h want count=%0d data=aa",
               acc_q.size() - n0, acc_q[acc_q.size()-1], 1);
    end
    checks++;
    if (high_cnt - h0 !== 1) begin
      errors++;
      $display("FAIL single_width: valid high %0d cycles want 1", high_cnt - h0);
    end
    checks++;
    if (fe_cnt !== f0) begin
      errors++;
      $display("FAIL single_flags: frame_err pulses %0d want 0", fe_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int n0, f0, o0;
    n0 = acc_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_cycles(20);
    checks++;
    if (acc_q.size() !== n0 + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes want 2", acc_q.size() - n0);
    end else begin
      checks++;
      if (acc_q[n0] !== 8'h55 || acc_q[n0+1] !== 8'h00) begin
        errors++;
        $display("FAIL b2b_data: got %h %h want 55 00", acc_q[n0], acc_q[n0+1]);
      end
    end
    checks++;
    if (fe_cnt !== f0 || ov_cnt !== o0) begin
      errors++;
      $display("FAIL b2b_flags: fe=%0d ov=%0d want 0 0", fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_glitch();
    int n0, f0;
    n0 = acc_q.size(); f0 = fe_cnt;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(40);
    checks++;
    if (acc_q.size() !== n0 || fe_cnt !== f0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: bytes=%0d fe=%0d valid=%b want 0 0 0",
               acc_q.size() - n0, fe_cnt - f0, valid);
    end
    send_frame(8'h3C, 1'b1);
    wait_cycles(20);
    checks++;
    if (acc_q.size() !== n0 + 1 || acc_q[acc_q.size()-1] !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_next: bytes=%0d last=%h want 1 3c",
               acc_q.size() - n0, acc_q[acc_q.size()-1]);
    end
  endtask

  task automatic test_break();
    int t0, n0, f0, o0;
    n0 = acc_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    t0 = cyc + 1;
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = 1'b1;
      wait_cycles(DIV);
    end
    rx = 1'b0;
    wait_cycles(40 * DIV);
    rx = 1'b1;
    wait_cycles(32);
    checks++;
    if (fe_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL break_fe_count: got %0d pulses want 1", fe_cnt - f0);
    end
    checks++;
    if (fe_cyc !== t0 + LAT) begin
      errors++;
      $display("FAIL break_fe_time: pulse at %0d want %0d", fe_cyc, t0 + LAT);
    end
    checks++;
    if (acc_q.size() !== n0 || ov_cnt !== o0) begin
      errors++;
      $display("FAIL break_no_valid: bytes=%0d ov=%0d want 0 0", acc_q.size() - n0, ov_cnt - o0);
    end
    send_frame(8'h81, 1'b1);
    wait_cycles(20);
    checks++;
    if (acc_q.size() !== n0 + 1 || acc_q[acc_q.size()-1] !== 8'h81) begin
      errors++;
      $display("FAIL break_recover: bytes=%0d last=%h want 1 81",
               acc_q.size() - n0, acc_q[acc_q.size()-1]);
    end
  endtask

  task automatic test_overrun();
    int t0, n0, o0, f0;
    n0 = acc_q.size(); o0 = ov_cnt; f0 = fe_cnt;
    ready = 1'b0;
    t0 = cyc + 1;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_cycles(20);
    checks++;
    if (ov_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d pulses want 1", ov_cnt - o0);
    end
    checks++;
    if (ov_cyc !== t0 + 10 * DIV + LAT) begin
      errors++;
      $display("FAIL overrun_time: pulse at %0d want %0d", ov_cyc, t0 + 10 * DIV + LAT);
    end
    checks++;
    if (valid !== 1'b1 || data !== 8'h12 || acc_q.size() !== n0 || fe_cnt !== f0 || both_cnt !== 0) begin
      errors++;
      $display("FAIL overrun_hold: valid=%b data=%h bytes=%0d fe=%0d both=%0d want 1 12 0 0 0",
               valid, data, acc_q.size() - n0, fe_cnt - f0, both_cnt);
    end
    ready = 1'b1;
    wait_cycles(1);
    checks++;
    if (valid !== 1'b0 || acc_q.size() !== n0 + 1 || acc_q[acc_q.size()-1] !== 8'h12) begin
      errors++;
      $display("FAIL overrun_release: valid=%b bytes=%0d last=%h want 0 1 12",
               valid, acc_q.size() - n0, acc_q[acc_q.size()-1]);
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    logic [7:0] b;
    n0 = acc_q.size();
    b = 8'h5A;
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cycles(DIV);
    end
    rx = b[4];
    wait_cycles(DIV / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b data=%h fe=%b ov=%b want 0 00 0 0",
               valid, data, frame_err, overrun);
    end
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(8 * DIV);
    checks++;
    if (acc_q.size() !== n0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard: bytes=%0d valid=%b want 0 0", acc_q.size() - n0, valid);
    end
    send_frame(8'hC3, 1'b1);
    wait_cycles(20);
    checks++;
    if (acc_q.size() !== n0 + 1 || acc_q[acc_q.size()-1] !== 8'hC3) begin
      errors++;
      $display("FAIL midreset_next: bytes=%0d last=%h want 1 c3",
               acc_q.size() - n0, acc_q[acc_q.size()-1]);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    cyc = 0; rise_cyc = -1; high_cnt = 0;
    fe_cnt = 0; fe_cyc = -1; ov_cnt = 0; ov_cyc = -1; both_cnt = 0;
    vprev = 1'b0;
    rx = 1'b1;
    ready = 1'b1;
    rst_n = 1'b0;
    #2;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_midframe();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL flags_exclusive: coincident pulses %0d want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx
